bundler_ch_seq: RTL

- Sequential, parametrised channel bundler for the HDC seizure-detection datapath.
- Accepts NUM_CHS channel hypervectors one per accepted beat over a valid/ready stream.
- Keeps a saturation-free per-dimension popcount and emits the bitwise majority hypervector on an output valid/ready stream.
- Replaces the all-channels-parallel combinational bundler. Adds even-channel-count tie-breaking, backpressure and abort.

---
 rtl/bundler_ch_seq.sv | 84 ++++++++
 1 files changed

// File: rtl/bundler_ch_seq.sv
// bundler_ch_seq: sequential majority bundler of NUM_CHS channel hypervectors over valid/ready streams
module bundler_ch_seq #(
    parameter int DIMENSIONS = 1024,
    parameter int NUM_CHS    = 17,
    localparam int CNT_W     = $clog2(NUM_CHS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIMENSIONS-1:0] hv_in,
    input  logic [DIMENSIONS-1:0] tie_hv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIMENSIONS-1:0] hvout,
    output logic [CNT_W-1:0]      ch_idx
);
    typedef enum logic {S_ACCUM, S_OUT} state_t;

    localparam logic [CNT_W:0]   NCH  = (CNT_W + 1)'(NUM_CHS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt [DIMENSIONS];
    logic [CNT_W-1:0]      w_cnt_nxt [DIMENSIONS];
    logic [CNT_W-1:0]      r_ch_idx;
    logic [DIMENSIONS-1:0] r_hvout;
    logic [DIMENSIONS-1:0] w_maj;
    logic                  w_acc;
    logic                  w_last;

    assign w_acc  = in_valid && in_ready && !clr;
    assign w_last = w_acc && (r_ch_idx == LAST);
    assign hvout  = r_hvout;
    assign ch_idx = r_ch_idx;

    // updated per-dimension counts and their majority; ties (even NUM_CHS only) take tie_hv
    always_comb begin
        for (int d = 0; d < DIMENSIONS; d++) begin
            w_cnt_nxt[d] = r_cnt[d] + CNT_W'(hv_in[d]);
            w_maj[d]     = ({w_cnt_nxt[d], 1'b0} > NCH) ? 1'b1 :
                           ({w_cnt_nxt[d], 1'b0} < NCH) ? 1'b0 : tie_hv[d];
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_ACCUM;
        else     r_state <= w_state_nxt;
    end

    // next state: clr always returns to ACCUM, otherwise leave OUT only on handshake
    always_comb begin
        w_state_nxt = clr ? S_ACCUM :
                      (r_state == S_ACCUM) ? (w_last ? S_OUT : S_ACCUM) :
                      (out_ready ? S_ACCUM : S_OUT);
    end

    // stream flags depend only on state, so out_ready never reaches in_ready combinationally
    always_comb begin
        in_ready  = (r_state == S_ACCUM);
        out_valid = (r_state == S_OUT);
    end

    // counters clear on abort or bundle completion; hvout captured on the last accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < DIMENSIONS; d++) r_cnt[d] <= '0;
            r_ch_idx <= '0;
            r_hvout  <= '0;
        end else begin
            if (clr || w_last) begin
                for (int d = 0; d < DIMENSIONS; d++) r_cnt[d] <= '0;
                r_ch_idx <= '0;
            end else if (w_acc) begin
                for (int d = 0; d < DIMENSIONS; d++) r_cnt[d] <= w_cnt_nxt[d];
                r_ch_idx <= r_ch_idx + 1'b1;
            end
            if (w_last) r_hvout <= w_maj;
        end
    end
endmodule
